// File: rtl/seq_divider_4bit.sv
// Multi-cycle unsigned 4-bit restoring divider, one quotient bit per clock.
// Ports: clk, rst, start, a, b in; q, r, busy, done, dbz out (all registered).

module nand_xor (
  input  logic x,
  input  logic y,
  output logic z
);
  logic n1, n2, n3;
  assign n1 = ~(x & y);
  assign n2 = ~(x & n1);
  assign n3 = ~(y & n1);
  assign z  = ~(n2 & n3);
endmodule

module and_cell (
  input  logic x,
  input  logic y,
  output logic z
);
  logic n;
  assign n = ~(x & y);
  assign z = ~(n & n);
endmodule

module or_cell (
  input  logic x,
  input  logic y,
  output logic z
);
  logic nx, ny;
  assign nx = ~(x & x);
  assign ny = ~(y & y);
  assign z  = ~(nx & ny);
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g, t;
  nand_xor u_x0 (.x(x),   .y(y),   .z(p));
  nand_xor u_x1 (.x(p),   .y(cin), .z(s));
  and_cell u_a0 (.x(x),   .y(y),   .z(g));
  and_cell u_a1 (.x(p),   .y(cin), .z(t));
  or_cell  u_o0 (.x(g),   .y(t),   .z(cout));
endmodule

module seq_divider_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       dbz
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] quo, rem, bl;
  logic [1:0] cnt;
  logic [4:0] shifted, sub_b, trial;
  logic [5:0] cy;
  logic       nonneg;
  logic [3:0] quo_n, rem_n;

  assign shifted = {rem, quo[3]};
  assign sub_b   = ~{1'b0, bl};
  assign cy[0]   = 1'b1;

  for (genvar i = 0; i < 5; i++) begin : g_sub
    fa_cell u_fa (
      .x   (shifted[i]),
      .y   (sub_b[i]),
      .cin (cy[i]),
      .s   (trial[i]),
      .cout(cy[i+1])
    );
  end

  // No-borrow and a clear sign bit agree over every reachable
  // shifted/bl pair; requiring both keeps the carry-out live.
  and_cell u_ok (.x(cy[5]), .y(~trial[4]), .z(nonneg));

  assign quo_n = {quo[2:0], nonneg};
  assign rem_n = nonneg ? trial[3:0] : shifted[3:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == 2'd3) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      quo   <= 4'd0;
      rem   <= 4'd0;
      bl    <= 4'd0;
      q     <= 4'd0;
      r     <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == CALC);
      done  <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            bl  <= b;
            quo <= a;
            rem <= 4'd0;
            cnt <= 2'd0;
          end
        end
        CALC: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            q   <= quo_n;
            r   <= rem_n;
            dbz <= (bl == 4'd0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
